// File: rtl/vga_timing_gen.sv
// Raster timing source for the game renderer: free-running pixel/line counters,
// registered display/frame/line strobes and polarity-adjusted, delayed VGA sync.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int SYNC_DLY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [10:0] x_pos,
   output logic [10:0] y_pos,
   output logic        display_en,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   if (H_TOTAL > 2048 || V_TOTAL > 2048 || SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_param_check
      $error("vga_timing_gen: timing parameters out of range");
   end

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        display_en_q, display_en_d;
   logic        frame_start_q, frame_start_d;
   logic        line_start_q, line_start_d;
   logic        hsync_raw_q, hsync_raw_d;
   logic        vsync_raw_q, vsync_raw_d;

   // Strobes and raw sync are decoded from the next-state counts so that, once
   // registered, they line up with x_pos/y_pos on the same cycle.
   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? 11'd0 : h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
      end
      display_en_d  = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      line_start_d  = (h_cnt_d == 11'd0);
      frame_start_d = (h_cnt_d == 11'd0) && (v_cnt_d == 11'd0);
      hsync_raw_d   = ((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST)) ? H_POL : !H_POL;
      vsync_raw_d   = ((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST)) ? V_POL : !V_POL;
   end

   // Reset parks the raster on the last blanking pixel so the first edge
   // after release starts a complete frame at (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= H_LAST;
         v_cnt_q       <= V_LAST;
         display_en_q  <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         hsync_raw_q   <= !H_POL;
         vsync_raw_q   <= !V_POL;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         display_en_q  <= display_en_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         hsync_raw_q   <= hsync_raw_d;
         vsync_raw_q   <= vsync_raw_d;
      end
   end

   assign x_pos       = h_cnt_q;
   assign y_pos       = v_cnt_q;
   assign display_en  = display_en_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

   // Sync is delayed to match the renderer's colour pipeline; the delay line
   // resets to the inactive level so no runt pulse follows a reset.
   if (SYNC_DLY == 0) begin : g_no_dly
      assign hsync = hsync_raw_q;
      assign vsync = vsync_raw_q;
   end else begin : g_dly
      logic hs_stage_q [SYNC_DLY];
      logic vs_stage_q [SYNC_DLY];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
               hs_stage_q[i] <= !H_POL;
               vs_stage_q[i] <= !V_POL;
            end
         end else begin
            hs_stage_q[0] <= hsync_raw_q;
            vs_stage_q[0] <= vsync_raw_q;
            for (int i = 1; i < SYNC_DLY; i++) begin
               hs_stage_q[i] <= hs_stage_q[i-1];
               vs_stage_q[i] <= vs_stage_q[i-1];
            end
         end
      end

      assign hsync = hs_stage_q[SYNC_DLY-1];
      assign vsync = vs_stage_q[SYNC_DLY-1];
   end

endmodule
